// File: rtl/seven_seg_reader_if.sv
// Bundle between a scanned seven-segment display bus and the frame reader.
// The slave side is the reader. The master side drives the display pins and the consumer ready.
interface seven_seg_reader_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg_n;
    logic [NDIG-1:0]   dig_en;
    logic              out_ready;
    logic              out_valid;
    logic [4*NDIG-1:0] out_value;
    logic [NDIG-1:0]   out_err;
    logic              overrun;

    modport master (
        output seg_n, dig_en, out_ready,
        input  out_valid, out_value, out_err, overrun
    );

    modport slave (
        input  seg_n, dig_en, out_ready,
        output out_valid, out_value, out_err, overrun
    );
endinterface

// File: rtl/seven_seg_reader.sv
// Recovers hex nibbles from a multiplexed active-low seven-segment bus.
// Each complete scan of all digits is offered as one word on a valid/ready output.
module seven_seg_reader #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    seven_seg_reader_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [6:0]        s_seg, p_seg;
    logic [NDIG-1:0]   s_dig, p_dig;
    logic [CW-1:0]     cnt, cnt_next;
    logic              armed, armed_next;
    logic [NDIG-1:0]   mask, mask_next;
    logic [4*NDIG-1:0] sh_val, sh_val_next;
    logic [NDIG-1:0]   sh_err, sh_err_next;
    logic [4*NDIG-1:0] val_r, val_next;
    logic [NDIG-1:0]   err_r, err_next;
    logic              valid_r, valid_next;
    logic              ovr_r, ovr_next;

    logic              dig_ok;
    logic              changed;
    logic              capture;
    logic              complete;
    logic              out_free;
    logic [IW-1:0]     dig_idx;
    logic [3:0]        dec_nib;
    logic              dec_err;

    // Patterns are g..a, active-low; anything outside the table decodes to 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1011000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0010000: r = 5'h09;
            7'b0001000: r = 5'h0A;
            7'b0000011: r = 5'h0B;
            7'b1000110: r = 5'h0C;
            7'b0100001: r = 5'h0D;
            7'b0000110: r = 5'h0E;
            7'b0001110: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        dig_ok  = (s_dig != '0) && ((s_dig & (s_dig - 1'b1)) == '0);
        changed = ({s_seg, s_dig} != {p_seg, p_dig});
        dig_idx = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (s_dig[k]) dig_idx = IW'(k);
        end
        {dec_err, dec_nib} = decode(s_seg);
    end

    // Stability counter saturates at the top; armed allows a single capture per dwell.
    always_comb begin
        cnt_next   = cnt;
        armed_next = armed;
        capture    = 1'b0;
        if (!dig_ok) begin
            cnt_next   = '0;
            armed_next = 1'b0;
        end else if (changed) begin
            cnt_next   = CNT_ONE;
            armed_next = 1'b1;
        end else if (cnt != CNT_TOP) begin
            cnt_next = cnt + CNT_ONE;
        end
        if (dig_ok && armed_next && (cnt_next == CNT_TOP)) begin
            capture    = 1'b1;
            armed_next = 1'b0;
        end
    end

    always_comb begin
        sh_val_next = sh_val;
        sh_err_next = sh_err;
        mask_next   = mask;
        val_next    = val_r;
        err_next    = err_r;
        valid_next  = valid_r && !bus.out_ready;
        ovr_next    = 1'b0;
        out_free    = !valid_r || bus.out_ready;

        if (capture) begin
            sh_val_next[4*dig_idx +: 4] = dec_nib;
            sh_err_next[dig_idx]        = dec_err;
            mask_next[dig_idx]          = 1'b1;
        end
        complete = capture && (&mask_next);

        // A completed frame either replaces the output word or is dropped whole.
        if (complete) begin
            mask_next = '0;
            if (out_free) begin
                val_next   = sh_val_next;
                err_next   = sh_err_next;
                valid_next = 1'b1;
            end else begin
                ovr_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg   <= '0;
            s_dig   <= '0;
            p_seg   <= '0;
            p_dig   <= '0;
            cnt     <= '0;
            armed   <= 1'b0;
            mask    <= '0;
            sh_val  <= '0;
            sh_err  <= '0;
            val_r   <= '0;
            err_r   <= '0;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            s_seg   <= bus.seg_n;
            s_dig   <= bus.dig_en;
            p_seg   <= s_seg;
            p_dig   <= s_dig;
            cnt     <= cnt_next;
            armed   <= armed_next;
            mask    <= mask_next;
            sh_val  <= sh_val_next;
            sh_err  <= sh_err_next;
            val_r   <= val_next;
            err_r   <= err_next;
            valid_r <= valid_next;
            ovr_r   <= ovr_next;
        end
    end

    assign bus.out_valid = valid_r;
    assign bus.out_value = val_r;
    assign bus.out_err   = err_r;
    assign bus.overrun   = ovr_r;
endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader with NDIG=4, STABLE_CYCLES=4.
module tb_seven_seg_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   frames = 0;
    int   ovr_cnt = 0;
    logic [15:0] last_val = '0;
    logic [3:0]  last_err = '0;

    seven_seg_reader_if #(.NDIG(4)) bus ();

    seven_seg_reader #(.NDIG(4), .STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            frames   = frames + 1;
            last_val = bus.out_value;
            last_err = bus.out_err;
        end
        if (!rst && bus.overrun) ovr_cnt = ovr_cnt + 1;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1011000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] dig, input logic [6:0] seg, input int n);
        bus.dig_en = dig;
        bus.seg_n  = seg;
        tick(n);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.seg_n     = 7'h7F;
        bus.dig_en    = '0;
        bus.out_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_value", 32'(bus.out_value), 32'h0);
        check("rst_err", 32'(bus.out_err), 32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);

        // basic frame 4321 with latency on the last digit
        show(4'b0001, seg_of(4'h1), 6);
        show(4'b0010, seg_of(4'h2), 6);
        show(4'b0100, seg_of(4'h3), 6);
        show(4'b1000, seg_of(4'h4), 4);
        check("lat_edge4_valid", 32'(bus.out_valid), 32'd0);
        tick(1);
        check("lat_edge5_valid", 32'(bus.out_valid), 32'd1);
        check("f1_value", 32'(bus.out_value), 32'h4321);
        check("f1_err", 32'(bus.out_err), 32'h0);
        tick(1);
        check("f1_xfer_drop", 32'(bus.out_valid), 32'd0);
        check("f1_frames", 32'(frames), 32'd1);
        check("f1_no_ovr", 32'(ovr_cnt), 32'd0);

        // glitch of 3 samples must not capture
        show(4'b0001, seg_of(4'h6), 3);
        show(4'b0001, seg_of(4'h0), 6);
        show(4'b0010, seg_of(4'h1), 6);
        show(4'b0100, seg_of(4'h2), 6);
        show(4'b1000, seg_of(4'h3), 6);
        check("glitch_frames", 32'(frames), 32'd2);
        check("glitch_value", 32'(last_val), 32'h3210);
        check("glitch_err", 32'(last_err), 32'h0);

        // unrecognised pattern on digit 2
        show(4'b0001, seg_of(4'h1), 6);
        show(4'b0010, seg_of(4'h2), 6);
        show(4'b0100, 7'b1111111, 6);
        show(4'b1000, seg_of(4'h4), 6);
        check("bad_frames", 32'(frames), 32'd3);
        check("bad_value", 32'(last_val), 32'h4021);
        check("bad_err", 32'(last_err), 32'b0100);

        // backpressure and overrun
        bus.out_ready = 1'b0;
        show(4'b0001, seg_of(4'h1), 6);
        show(4'b0010, seg_of(4'h2), 6);
        show(4'b0100, seg_of(4'h3), 6);
        show(4'b1000, seg_of(4'h4), 6);
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_value", 32'(bus.out_value), 32'h4321);
        check("hold_no_ovr", 32'(ovr_cnt), 32'd0);
        show(4'b0001, seg_of(4'h5), 6);
        show(4'b0010, seg_of(4'h6), 6);
        show(4'b0100, seg_of(4'h7), 6);
        show(4'b1000, seg_of(4'h8), 4);
        check("ovr_before", 32'(bus.overrun), 32'd0);
        tick(1);
        check("ovr_pulse", 32'(bus.overrun), 32'd1);
        check("ovr_value_kept", 32'(bus.out_value), 32'h4321);
        check("ovr_valid_kept", 32'(bus.out_valid), 32'd1);
        tick(1);
        check("ovr_one_cycle", 32'(bus.overrun), 32'd0);
        check("ovr_count", 32'(ovr_cnt), 32'd1);
        bus.out_ready = 1'b1;
        tick(1);
        check("late_xfer_drop", 32'(bus.out_valid), 32'd0);
        check("late_xfer_frames", 32'(frames), 32'd4);
        check("late_xfer_value", 32'(last_val), 32'h4321);

        // invalid digit selects capture nothing
        bus.out_ready = 1'b0;
        show(4'b0000, seg_of(4'h9), 10);
        show(4'b0011, seg_of(4'h9), 10);
        check("sel_valid", 32'(bus.out_valid), 32'd0);
        check("sel_value", 32'(bus.out_value), 32'h4321);
        show(4'b0010, seg_of(4'h5), 6);
        show(4'b0100, seg_of(4'h6), 6);
        show(4'b1000, seg_of(4'h7), 6);
        check("sel_no_digit0", 32'(bus.out_valid), 32'd0);
        show(4'b0001, seg_of(4'h9), 4);
        check("sel_edge4", 32'(bus.out_valid), 32'd0);
        tick(1);
        check("sel_complete", 32'(bus.out_valid), 32'd1);
        check("sel_frame_value", 32'(bus.out_value), 32'h7659);

        // asynchronous reset mid-frame
        show(4'b0001, seg_of(4'hA), 6);
        show(4'b0010, seg_of(4'hB), 6);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_value", 32'(bus.out_value), 32'h0);
        check("arst_err", 32'(bus.out_err), 32'h0);
        tick(2);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        show(4'b0100, seg_of(4'hC), 6);
        show(4'b1000, seg_of(4'hD), 6);
        check("arst_partial", 32'(bus.out_valid), 32'd0);
        check("arst_frames", 32'(frames), 32'd4);
        show(4'b0001, seg_of(4'hE), 6);
        show(4'b0010, seg_of(4'hF), 4);
        check("arst_edge4", 32'(bus.out_valid), 32'd0);
        tick(1);
        check("arst_complete", 32'(bus.out_valid), 32'd1);
        check("arst_value_new", 32'(bus.out_value), 32'hDCFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
